spectrum_ram_arbiter: RTL and testbench
=======================================

# spectrum_ram_arbiter

Arbitrates the single-port spectrum RAM between the FFT magnitude writer and the display path. On every `frame_pulse` from the VGA sync/control generator, it copies all bar heights from the spectrum RAM into the display-side bar register file. While that snapshot runs, writer access is stalled, so each rendered frame shows a coherent, tear-free spectrum. It sits between the audio/FFT pipeline and the bar renderer, clocked on the pixel clock.

## Interface
- `NUM_BINS`, 64: number of spectrum bins (RAM depth), ≥2.
- `ADDR_WIDTH`, 6: bin address width, 2^ADDR_WIDTH ≥ NUM_BINS.
- `DATA_WIDTH`, 9: bar height width (0..511, covers 480 lines).
- `clk` in 1: pixel clock, single clock domain.
- `resetn` in 1: reset, asynchronous and active-low.
- `frame_pulse` in 1: one-cycle pulse from the sync generator at the start of vertical blanking.
- `cfg_freeze` in 1: when high, snapshots are skipped and the display holds its last frame.
- `wr_valid` in 1: writer request.
- `wr_ready` out 1: writer grant; a transfer occurs when `wr_valid && wr_ready`.
- `wr_addr` in ADDR_WIDTH: bin index to write.
- `wr_data` in DATA_WIDTH: bar height to write.
- `ram_en` out 1: RAM access enable.
- `ram_we` out 1: RAM write enable.
- `ram_addr` out ADDR_WIDTH: RAM address.
- `ram_wdata` out DATA_WIDTH: RAM write data.
- `ram_rdata` in DATA_WIDTH: RAM read data, valid one cycle after a read.
- `snap_we` out 1: display regfile write strobe.
- `snap_addr` out ADDR_WIDTH: display regfile address.
- `snap_data` out DATA_WIDTH: display regfile data.
- `snap_done` out 1: one-cycle pulse on the final snapshot write.
- `overrun` out 1: sticky flag; set when `frame_pulse` arrives while the FSM is not IDLE.

## Operation
- FSM states are IDLE, FETCH and DRAIN. Reset state is IDLE.
- IDLE:
  - `wr_ready = !frame_pulse` (combinational).
  - An accepted write drives `ram_en=1`, `ram_we=1`, `ram_addr=wr_addr`, `ram_wdata=wr_data` in the same cycle.
  - `frame_pulse && !cfg_freeze` → FETCH with the read counter at 0.
  - `frame_pulse && cfg_freeze` → stay in IDLE; no snapshot occurs.
- FETCH:
  - `wr_ready=0`.
  - Each cycle drives `ram_en=1`, `ram_we=0`, `ram_addr=rd_cnt`, then increments `rd_cnt`.
  - When `rd_cnt == NUM_BINS-1` → DRAIN.
- DRAIN: one cycle, `wr_ready=0`, no RAM access, then → IDLE.
- Snapshot write path:
  - A registered pipeline flag `rd_pend` is set one cycle after each FETCH read.
  - `snap_we = rd_pend`, `snap_addr` = the delayed read address, `snap_data = ram_rdata`.
  - `snap_done = snap_we && snap_addr == NUM_BINS-1`.
- When no RAM access is active, `ram_en=0`, `ram_we=0`, and `ram_addr`/`ram_wdata` are 0.
- Arbitration rules:
  - `frame_pulse` beats the writer in the same cycle; the writer simply waits with `wr_valid` held.
  - No write is ever dropped.
- `overrun`:
  - Set by `frame_pulse` arriving in FETCH or DRAIN. That pulse is ignored.
  - Cleared only by reset.
- Addresses ≥ NUM_BINS on `wr_addr` are passed through unchecked.

## Timing
- `frame_pulse` high at cycle T, in IDLE, not frozen:
  - Reads are issued at T+1 … T+NUM_BINS.
  - `snap_we` is high at T+2 … T+NUM_BINS+1.
  - `snap_done` pulses at T+NUM_BINS+1.
  - The FSM is back in IDLE at T+NUM_BINS+2.
- Writer stall is exactly NUM_BINS+2 cycles, T through T+NUM_BINS+1.
- Write latency: 0 cycles from handshake to `ram_we`.
- Snapshot latency is one cycle from read address to `snap_we`, matching the RAM read latency.
- Reset values: FSM=IDLE, `rd_cnt=0`, `rd_pend=0`, `snap_*=0`, `snap_done=0`, `overrun=0`. `wr_ready` follows IDLE.
- Reset asserted mid-snapshot:
  - All outputs return to reset values immediately.
  - The partially written display regfile is left as is.
  - The next `frame_pulse` performs a full snapshot.

## Configuration
- `SPECTRUM_ARB_STATS_EN`:
  - Defined: adds output `stat_wr_stall_cycles` (16 bits, saturating). It counts cycles with `wr_valid && !wr_ready` and resets to 0.
  - Undefined: the port and the counter are absent; all other behaviour is identical.

## Structure
- Shared package `spectrum_pkg`:
  - FSM state encoding (IDLE/FETCH/DRAIN).
  - Default `NUM_BINS`, `ADDR_WIDTH`, `DATA_WIDTH` constants.
  - Stats counter width.
- Sub-module `spectrum_arb_stats`: the saturating stall counter, instantiated only under `SPECTRUM_ARB_STATS_EN`.

## Test plan
- Reset, NUM_BINS=64, RAM preloaded with addr+1, `frame_pulse` at T → 64 `snap_we`s at T+2..T+65 carrying data 1..64; `snap_done` at T+65; `wr_ready` high again at T+66.
- `wr_valid` held with addr 5 / data 300 when `frame_pulse` arrives → no write until T+66; a single `ram_we` at T+66 with addr 5 / data 300.
- `cfg_freeze=1`, `frame_pulse` pulsed → no `snap_we`, `wr_ready` drops only for the pulse cycle, `overrun` stays 0.
- Second `frame_pulse` at T+30 → `overrun=1`, the snapshot still ends at T+65, and no second snapshot follows.
- `resetn` low at T+20 → `snap_we=0` and FSM in IDLE immediately; after release, `frame_pulse` → a full 64-entry snapshot.
- `SPECTRUM_ARB_STATS_EN` defined, writer blocked through one snapshot → `stat_wr_stall_cycles=66`.

Source files
------------

// File: rtl/spectrum_pkg.sv
// spectrum_pkg
// Shared definitions for the spectrum RAM arbiter slice.
//   - arb_state_t : arbiter FSM state encoding (IDLE / FETCH / DRAIN)
//   - DEF_*       : default geometry of the spectrum RAM and bar heights
//   - STAT_WIDTH  : width of the optional writer-stall statistics counter
package spectrum_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } arb_state_t;

  localparam int DEF_NUM_BINS   = 64;
  localparam int DEF_ADDR_WIDTH = 6;
  localparam int DEF_DATA_WIDTH = 9;
  localparam int STAT_WIDTH     = 16;

endpackage

// File: rtl/spectrum_arb_stats.sv
// spectrum_arb_stats
// Saturating counter of cycles in which the FFT writer is held off.
// Ports:
//   clk, resetn  : pixel clock, asynchronous active-low reset
//   stall        : writer requesting but not granted this cycle
//   stall_cycles : saturating count of stalled cycles
module spectrum_arb_stats
  import spectrum_pkg::*;
(
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  stall,
  output logic [STAT_WIDTH-1:0] stall_cycles
);

  // Stops at all-ones so a long run never wraps back to a small value.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_cycles <= '0;
    end else if (stall && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + STAT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/spectrum_ram_arbiter.sv
// spectrum_ram_arbiter
// Shares the single-port spectrum RAM between the FFT magnitude writer and
// the display path. Each frame_pulse (unless frozen) copies every bin into
// the display bar register file while the writer is stalled, so a rendered
// frame never mixes two spectra.
// Ports:
//   clk, resetn            : pixel clock, asynchronous active-low reset
//   frame_pulse            : start of vertical blanking, one cycle
//   cfg_freeze             : skip snapshots, display keeps its last frame
//   wr_valid/wr_ready      : writer handshake, wr_addr/wr_data payload
//   ram_en/we/addr/wdata   : single-port RAM control, ram_rdata 1-cycle read
//   snap_we/addr/data      : display register file write port
//   snap_done              : pulse on the last snapshot write
//   overrun                : sticky, frame_pulse seen while busy
//   stat_wr_stall_cycles   : only when SPECTRUM_ARB_STATS_EN is defined
module spectrum_ram_arbiter
  import spectrum_pkg::*;
#(
  parameter int NUM_BINS   = DEF_NUM_BINS,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  frame_pulse,
  input  logic                  cfg_freeze,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  snap_we,
  output logic [ADDR_WIDTH-1:0] snap_addr,
  output logic [DATA_WIDTH-1:0] snap_data,
  output logic                  snap_done,
`ifdef SPECTRUM_ARB_STATS_EN
  output logic [STAT_WIDTH-1:0] stat_wr_stall_cycles,
`endif
  output logic                  overrun
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_BINS - 1);

  arb_state_t            state;
  arb_state_t            next_state;
  logic [ADDR_WIDTH-1:0] rd_cnt;
  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic                  rd_pend;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // frame_pulse wins over the writer in IDLE, so the grant is withdrawn in
  // the pulse cycle itself and the writer keeps its request up until IDLE.
  always_comb begin
    next_state = state;
    wr_ready   = 1'b0;
    ram_en     = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = '0;
    ram_wdata  = '0;
    case (state)
      IDLE: begin
        wr_ready = !frame_pulse;
        if (wr_valid && !frame_pulse) begin
          ram_en    = 1'b1;
          ram_we    = 1'b1;
          ram_addr  = wr_addr;
          ram_wdata = wr_data;
        end
        if (frame_pulse && !cfg_freeze) begin
          next_state = FETCH;
        end
      end
      FETCH: begin
        ram_en   = 1'b1;
        ram_addr = rd_cnt;
        if (rd_cnt == LAST_ADDR) begin
          next_state = DRAIN;
        end
      end
      DRAIN: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Read counter restarts at 0 whenever FETCH is not active, so every
  // snapshot (including one after a reset mid-copy) covers all bins. The
  // read address is delayed by one cycle to line up with ram_rdata.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_cnt    <= '0;
      rd_pend   <= 1'b0;
      rd_addr_q <= '0;
      overrun   <= 1'b0;
    end else begin
      rd_pend   <= (state == FETCH);
      rd_addr_q <= (state == FETCH) ? rd_cnt : '0;
      if (state == FETCH && rd_cnt != LAST_ADDR) begin
        rd_cnt <= rd_cnt + ADDR_WIDTH'(1);
      end else begin
        rd_cnt <= '0;
      end
      if (frame_pulse && state != IDLE) begin
        overrun <= 1'b1;
      end
    end
  end

  assign snap_we   = rd_pend;
  assign snap_addr = rd_addr_q;
  assign snap_data = rd_pend ? ram_rdata : '0;
  assign snap_done = rd_pend && (rd_addr_q == LAST_ADDR);

`ifdef SPECTRUM_ARB_STATS_EN
  spectrum_arb_stats u_stats (
    .clk          (clk),
    .resetn       (resetn),
    .stall        (wr_valid && !wr_ready),
    .stall_cycles (stat_wr_stall_cycles)
  );
`endif

endmodule

// File: tb/tb_spectrum_ram_arbiter.sv
// tb_spectrum_ram_arbiter
// Directed bench for spectrum_ram_arbiter with a behavioural 1-cycle-latency
// single-port RAM. Stats checks are compiled in with SPECTRUM_ARB_STATS_EN.
module tb_spectrum_ram_arbiter;
  import spectrum_pkg::*;

  logic       clk = 1'b0;
  logic       resetn;
  logic       frame_pulse;
  logic       cfg_freeze;
  logic       wr_valid;
  logic       wr_ready;
  logic [5:0] wr_addr;
  logic [8:0] wr_data;
  logic       ram_en;
  logic       ram_we;
  logic [5:0] ram_addr;
  logic [8:0] ram_wdata;
  logic [8:0] ram_rdata = '0;
  logic       snap_we;
  logic [5:0] snap_addr;
  logic [8:0] snap_data;
  logic       snap_done;
  logic       overrun;
`ifdef SPECTRUM_ARB_STATS_EN
  logic [STAT_WIDTH-1:0] stat_wr_stall_cycles;
`endif

  logic [8:0] mem [0:63];

  int vectors     = 0;
  int miscompares = 0;

  int snapWeCount, snapFirstK, snapLastK, snapDataErr;
  int snapDoneCount, snapDoneK, wrReadyBackK, notReadyCount;
  int ramWeCount, ramWeK, ramWeAddr, ramWeData;
  int snapWeAtReset, readyAtReset;

  spectrum_ram_arbiter #(.NUM_BINS(64), .ADDR_WIDTH(6), .DATA_WIDTH(9)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .frame_pulse (frame_pulse),
    .cfg_freeze  (cfg_freeze),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .ram_en      (ram_en),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata),
    .snap_we     (snap_we),
    .snap_addr   (snap_addr),
    .snap_data   (snap_data),
    .snap_done   (snap_done),
`ifdef SPECTRUM_ARB_STATS_EN
    .stat_wr_stall_cycles (stat_wr_stall_cycles),
`endif
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  // Single-port RAM, one cycle read latency.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  task automatic checkOutput(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic preloadRam();
    for (int i = 0; i < 64; i++) mem[i] = 9'(i + 1);
  endtask

  // Runs `cycles` cycles starting at cycle T (k=0) with frame_pulse at k=0,
  // an optional second pulse, an optional one-cycle reset, and an optional
  // writer (addr 5 / data 300) raised at k=0 and held until granted.
  task automatic applyStimulus(input int pulse2K, input bit freeze,
                               input int resetK, input bit holdWriter,
                               input int cycles);
    bit writerPending = holdWriter;
    snapWeCount = 0; snapFirstK = -1; snapLastK = -1; snapDataErr = 0;
    snapDoneCount = 0; snapDoneK = -1; wrReadyBackK = -1; notReadyCount = 0;
    ramWeCount = 0; ramWeK = -1; ramWeAddr = -1; ramWeData = -1;
    snapWeAtReset = -1; readyAtReset = -1;
    for (int k = 0; k < cycles; k++) begin
      frame_pulse = (k == 0) || (k == pulse2K);
      cfg_freeze  = freeze;
      resetn      = (k != resetK);
      wr_valid    = writerPending;
      wr_addr     = 6'd5;
      wr_data     = 9'd300;
      #3;
      if (snap_we) begin
        snapWeCount++;
        if (snapFirstK < 0) snapFirstK = k;
        snapLastK = k;
        if (int'(snap_addr) != k - snapFirstK || int'(snap_data) != k - snapFirstK + 1)
          snapDataErr++;
      end
      if (snap_done) begin
        snapDoneCount++;
        snapDoneK = k;
      end
      if (!wr_ready) notReadyCount++;
      else if (k > 0 && wrReadyBackK < 0) wrReadyBackK = k;
      if (ram_en && ram_we) begin
        ramWeCount++;
        ramWeK = k; ramWeAddr = int'(ram_addr); ramWeData = int'(ram_wdata);
      end
      if (k == resetK) begin
        snapWeAtReset = int'(snap_we);
        readyAtReset  = int'(wr_ready);
      end
      if (wr_valid && wr_ready) writerPending = 1'b0;
      @(posedge clk); #1;
    end
    frame_pulse = 1'b0;
    wr_valid    = 1'b0;
    resetn      = 1'b1;
  endtask

  initial begin
    resetn = 1'b0; frame_pulse = 1'b0; cfg_freeze = 1'b0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    preloadRam();
    repeat (3) @(posedge clk);
    #4;
    checkOutput("rst_wr_ready", int'(wr_ready), 1);
    checkOutput("rst_ram_en", int'(ram_en), 0);
    checkOutput("rst_snap_we", int'(snap_we), 0);
    checkOutput("rst_snap_addr", int'(snap_addr), 0);
    checkOutput("rst_snap_data", int'(snap_data), 0);
    checkOutput("rst_snap_done", int'(snap_done), 0);
    checkOutput("rst_overrun", int'(overrun), 0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;

    $display("[TB] idle write");
    wr_valid = 1'b1; wr_addr = 6'd10; wr_data = 9'd77;
    #3;
    checkOutput("idle_ram_en", int'(ram_en), 1);
    checkOutput("idle_ram_we", int'(ram_we), 1);
    checkOutput("idle_ram_addr", int'(ram_addr), 10);
    checkOutput("idle_ram_wdata", int'(ram_wdata), 77);
    @(posedge clk); #1;
    wr_valid = 1'b0;
    #3;
    checkOutput("idle_mem10", int'(mem[10]), 77);
    checkOutput("noacc_ram_en", int'(ram_en), 0);
    checkOutput("noacc_ram_addr", int'(ram_addr), 0);
    checkOutput("noacc_ram_wdata", int'(ram_wdata), 0);
    @(posedge clk); #1;

    $display("[TB] snapshot with writer held");
    preloadRam();
    applyStimulus(-1, 1'b0, -1, 1'b1, 70);
    checkOutput("snap_count", snapWeCount, 64);
    checkOutput("snap_first", snapFirstK, 2);
    checkOutput("snap_last", snapLastK, 65);
    checkOutput("snap_data_err", snapDataErr, 0);
    checkOutput("snap_done_count", snapDoneCount, 1);
    checkOutput("snap_done_cycle", snapDoneK, 65);
    checkOutput("ready_back", wrReadyBackK, 66);
    checkOutput("stall_cycles", notReadyCount, 66);
    checkOutput("wr_count", ramWeCount, 1);
    checkOutput("wr_cycle", ramWeK, 66);
    checkOutput("wr_addr", ramWeAddr, 5);
    checkOutput("wr_data", ramWeData, 300);
    checkOutput("mem5", int'(mem[5]), 300);
    checkOutput("snap_overrun", int'(overrun), 0);
`ifdef SPECTRUM_ARB_STATS_EN
    checkOutput("stat_stall", int'(stat_wr_stall_cycles), 66);
`endif

    $display("[TB] frozen pulse");
    preloadRam();
    applyStimulus(-1, 1'b1, -1, 1'b0, 10);
    checkOutput("frz_snap_count", snapWeCount, 0);
    checkOutput("frz_not_ready", notReadyCount, 1);
    checkOutput("frz_ready_back", wrReadyBackK, 1);
    checkOutput("frz_overrun", int'(overrun), 0);

    $display("[TB] second pulse during snapshot");
    applyStimulus(30, 1'b0, -1, 1'b0, 140);
    checkOutput("ovr_flag", int'(overrun), 1);
    checkOutput("ovr_snap_count", snapWeCount, 64);
    checkOutput("ovr_done_cycle", snapDoneK, 65);
    checkOutput("ovr_done_count", snapDoneCount, 1);
    checkOutput("ovr_ready_back", wrReadyBackK, 66);

    $display("[TB] reset mid-snapshot");
    applyStimulus(-1, 1'b0, 20, 1'b0, 30);
    checkOutput("mid_rst_snap_we", snapWeAtReset, 0);
    checkOutput("mid_rst_ready", readyAtReset, 1);
    checkOutput("mid_rst_overrun", int'(overrun), 0);
    checkOutput("mid_rst_partial", snapWeCount, 18);

    $display("[TB] full snapshot after reset");
    applyStimulus(-1, 1'b0, -1, 1'b0, 70);
    checkOutput("post_snap_count", snapWeCount, 64);
    checkOutput("post_snap_first", snapFirstK, 2);
    checkOutput("post_data_err", snapDataErr, 0);
    checkOutput("post_done_cycle", snapDoneK, 65);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
